eae_unit: RTL
=============

# eae_unit

Extended Arithmetic Element for the PDP-8 core. It performs the iterative MUL and DVI operations and sits directly upstream of the CPU datapath. The controller issues a one-cycle start with the operands. The unit iterates, then presents results on `ac_mul`/`mq_mul` or `ac_dvi`/`mq_dvi`/`link_dvi`, which the CPU loads when the controller selects AC_MUL/MQ_MUL or AC_DVI/MQ_DVI/LK_DVI.

## Interface
Parameters:
- WIDTH, 12, word width; the unit is built and verified only at 12.

Ports:
- clock  in  1  system clock, rising edge.
- resetN  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle request; sampled on the rising edge; ignored while busy.
- op  in  1  0 = MUL, 1 = DVI; sampled with start.
- ac_in  in  WIDTH  current AC; high half of the dividend for DVI; unused for MUL.
- mq_in  in  WIDTH  current MQ; multiplier for MUL, low half of the dividend for DVI.
- operand  in  WIDTH  memory operand (MB); multiplicand or divisor.
- busy  out  1  high from the cycle after acceptance through the done cycle.
- done  out  1  one-cycle pulse; results valid and stable from this cycle on.
- ac_mul  out  WIDTH  high 12 bits of the product.
- mq_mul  out  WIDTH  low 12 bits of the product.
- ac_dvi  out  WIDTH  remainder.
- mq_dvi  out  WIDTH  quotient.
- link_dvi  out  1  divide overflow flag.

## Operation
- States: IDLE, MUL, DIV, DONE. A 4-bit iteration counter runs 0..11.
- Acceptance:
  - start is accepted in IDLE only.
  - On acceptance, the unit latches operand into the divisor/multiplicand register, loads the iteration counter with 0, and moves to MUL or DIV according to op.
- MUL:
  - Product = mq_in × operand, computed by 12-cycle shift-add on a 25-bit accumulator {carry, P_hi, P_lo}.
  - P_lo starts as mq_in and P_hi starts at 0.
  - Each cycle: if P_lo[0] = 1, add operand to P_hi; then shift {carry, P_hi, P_lo} right by 1.
  - After 12 iterations, the FSM goes to DONE. ac_mul <= P_hi and mq_mul <= P_lo.
  - The product is exact and cannot overflow.
  - The CPU clears the link for MUL itself, so the unit has no link output for MUL.
- DVI overflow check:
  - Overflow is checked at acceptance: ac_in >= operand. A zero divisor therefore always overflows.
  - On overflow: go directly to DONE. link_dvi <= 1, ac_dvi <= ac_in, mq_dvi <= mq_in, so AC and MQ are left unchanged.
- DVI normal path:
  - Uses 12-cycle restoring division on a 13-bit remainder R = {0, ac_in} and a shifted quotient Q = mq_in.
  - Each cycle: shift {R, Q} left by 1. If R >= divisor, subtract the divisor and set Q[0] = 1; otherwise Q[0] = 0.
  - After 12 iterations: mq_dvi <= Q, ac_dvi <= R[11:0], link_dvi <= 0.
- DONE:
  - done = 1 for exactly one cycle, then the FSM returns to IDLE.
- Result holding:
  - Result outputs are registers. The MUL pair updates only when a MUL completes; the DVI triple updates only when a DVI completes.
  - All result registers hold their values indefinitely otherwise.
- Arithmetic rules:
  - All values are unsigned.
  - Internal add and subtract results are one bit wider than their operands; there is no truncation until the final 12-bit outputs.
- Reset:
  - resetN low drives the FSM to IDLE and clears the counter, busy, done, all result outputs and all internal registers, all to 0.
  - This takes effect immediately, including mid-operation.
  - The interrupted operation produces no done and no result update.

## Timing
- Cycle numbering: start is high in cycle 0 and accepted at the end of cycle 0.
- MUL and non-overflow DVI:
  - busy is high in cycles 1–13.
  - The 12 iterations run in cycles 1–12.
  - done is high in cycle 13; results are visible in cycle 13.
  - busy is low in cycle 14; start is accepted again from cycle 14.
- DVI overflow:
  - busy and done are high in cycle 1; results are visible in cycle 1.
  - Idle again in cycle 2.
- start during busy (including the DONE cycle) is dropped. It is not queued.
- Inputs ac_in, mq_in and operand need to be valid only in cycle 0. Later changes have no effect.
- After resetN deasserts, start is accepted on the first rising edge.

## Test plan
- MUL: mq_in = 7777₈, operand = 7777₈ -> done in cycle 13; ac_mul = 7776₈, mq_mul = 0001₈; DVI outputs unchanged.
- DVI normal: ac_in = 0, mq_in = 0144₈ (100), operand = 7 -> done in cycle 13; mq_dvi = 0016₈ (14), ac_dvi = 2, link_dvi = 0.
- DVI overflow: ac_in = 0005₈, mq_in = 1234₈, operand = 0005₈ -> done in cycle 1; link_dvi = 1, ac_dvi = 0005₈, mq_dvi = 1234₈.
  - Repeat with operand = 0 -> same overflow response.
- Busy rejection: start a MUL of 3 × 4, then pulse start with op = DVI in cycles 5 and 13 -> exactly one done, in cycle 13; ac_mul = 0, mq_mul = 0014₈; DVI outputs unchanged.
  - A new start in cycle 14 is accepted.
- Reset mid-operation: assert resetN low in cycle 6 of a MUL -> busy, done and all outputs go to 0 asynchronously; no done follows.
  - A following MUL of 2 × 3 yields mq_mul = 6, ac_mul = 0 in cycle 13.
- Back-to-back: DVI (ac_in = 0, mq_in = 12, operand = 5) immediately followed in cycle 14 by MUL (mq_in = 5, operand = 5) -> mq_dvi = 2, ac_dvi = 2 held while mq_mul = 0031₈ (25) appears in cycle 27.

Source files
------------

// File: rtl/eae_unit.sv
// eae_unit: PDP-8 Extended Arithmetic Element.
// Iterative 12-cycle shift-add multiply (MUL) and restoring divide (DVI), with the
// divide-overflow check done up front so an overflowing DVI finishes in one cycle.
module eae_unit #(
    parameter int unsigned WIDTH = 12
) (
    input  logic             clock,
    input  logic             resetN,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] ac_in,
    input  logic [WIDTH-1:0] mq_in,
    input  logic [WIDTH-1:0] operand,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] ac_mul,
    output logic [WIDTH-1:0] mq_mul,
    output logic [WIDTH-1:0] ac_dvi,
    output logic [WIDTH-1:0] mq_dvi,
    output logic             link_dvi
);

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_t;

    localparam logic [3:0] LastIter = 4'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [3:0]       r_cnt;
    logic [WIDTH-1:0] r_div;      // latched multiplicand / divisor
    logic [WIDTH-1:0] r_hi;       // P_hi for MUL, remainder R for DVI
    logic [WIDTH-1:0] r_lo;       // P_lo for MUL, quotient Q for DVI
    logic [WIDTH-1:0] r_ac_mul;
    logic [WIDTH-1:0] r_mq_mul;
    logic [WIDTH-1:0] r_ac_dvi;
    logic [WIDTH-1:0] r_mq_dvi;
    logic             r_link_dvi;

    logic             w_ovf;
    logic             w_last;
    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH-1:0] w_mul_hi;
    logic [WIDTH-1:0] w_mul_lo;
    logic [WIDTH:0]   w_div_rem_sh;
    logic [WIDTH+1:0] w_div_diff;
    logic             w_div_ge;
    logic [WIDTH-1:0] w_div_rem;
    logic [WIDTH-1:0] w_div_q;

    assign w_ovf  = (ac_in >= operand);
    assign w_last = (r_cnt == LastIter);

    // The carry bit only lives between the add and the shift, so it is not stored.
    assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_div} : '0);
    assign w_mul_hi  = w_mul_sum[WIDTH:1];
    assign w_mul_lo  = {w_mul_sum[0], r_lo[WIDTH-1:1]};

    // R stays below the divisor between iterations, so its top bit is always 0 and only
    // the shifted value needs the extra bit.
    assign w_div_rem_sh = {r_hi, r_lo[WIDTH-1]};
    assign w_div_diff   = {1'b0, w_div_rem_sh} - {2'b00, r_div};
    assign w_div_ge     = ~w_div_diff[WIDTH+1];
    assign w_div_rem    = w_div_ge ? w_div_diff[WIDTH-1:0] : w_div_rem_sh[WIDTH-1:0];
    assign w_div_q      = {r_lo[WIDTH-2:0], w_div_ge};

    // State register.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and status outputs.
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b1;
        done        = 1'b0;
        case (r_state)
            StIdle: begin
                busy = 1'b0;
                if (start) begin
                    if (!op)        w_state_nxt = StMul;
                    else if (w_ovf) w_state_nxt = StDone;
                    else            w_state_nxt = StDiv;
                end
            end
            StMul:   if (w_last) w_state_nxt = StDone;
            StDiv:   if (w_last) w_state_nxt = StDone;
            default: begin
                done        = 1'b1;
                w_state_nxt = StIdle;
            end
        endcase
    end

    // Datapath iteration and result registers; results load on the final iteration
    // so they are visible in the DONE cycle.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_cnt      <= '0;
            r_div      <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_ac_mul   <= '0;
            r_mq_mul   <= '0;
            r_ac_dvi   <= '0;
            r_mq_dvi   <= '0;
            r_link_dvi <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (start) begin
                        r_div <= operand;
                        r_cnt <= '0;
                        r_lo  <= mq_in;
                        r_hi  <= op ? ac_in : '0;
                        if (op && w_ovf) begin
                            r_link_dvi <= 1'b1;
                            r_ac_dvi   <= ac_in;
                            r_mq_dvi   <= mq_in;
                        end
                    end
                end
                StMul: begin
                    r_hi  <= w_mul_hi;
                    r_lo  <= w_mul_lo;
                    r_cnt <= w_last ? '0 : r_cnt + 4'd1;
                    if (w_last) begin
                        r_ac_mul <= w_mul_hi;
                        r_mq_mul <= w_mul_lo;
                    end
                end
                StDiv: begin
                    r_hi  <= w_div_rem;
                    r_lo  <= w_div_q;
                    r_cnt <= w_last ? '0 : r_cnt + 4'd1;
                    if (w_last) begin
                        r_ac_dvi   <= w_div_rem;
                        r_mq_dvi   <= w_div_q;
                        r_link_dvi <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ac_mul   = r_ac_mul;
    assign mq_mul   = r_mq_mul;
    assign ac_dvi   = r_ac_dvi;
    assign mq_dvi   = r_mq_dvi;
    assign link_dvi = r_link_dvi;

endmodule
